// File: rtl/router_rr_arbiter.sv
// rtl/router_rr_arbiter.sv - round-robin switch arbiter with per-output holding slots (optional stats: ROUTER_ARB_STATS_EN)
module router_rr_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  localparam int PW        = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] in_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]            in_valid,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_PORTS-1:0]            out_valid,
  input  logic [NUM_PORTS-1:0]            out_ready,
  output logic [NUM_PORTS*PW-1:0]         out_src
`ifdef ROUTER_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*16-1:0]         grant_count
`endif
);

  logic [PW-1:0]                 dest [NUM_PORTS];
  logic [PW-1:0]                 ptr_q [NUM_PORTS];
  logic [PW-1:0]                 ptr_d [NUM_PORTS];
  logic [PW-1:0]                 win_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0]          win_found;
  logic [NUM_PORTS-1:0]          can_load;
  logic [NUM_PORTS-1:0]          grant;
  logic [PW-1:0]                 scan_idx;
  logic [NUM_PORTS-1:0]          out_valid_q, out_valid_d;
  logic [NUM_PORTS*DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [NUM_PORTS*PW-1:0]       out_src_q, out_src_d;

  // Only the low PW address bits select the destination; the rest are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^in_addr;

  // Destination decode from the low address bits of each input.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      dest[i] = in_addr[i*ADDR_WIDTH +: PW];
    end
  end

  // Per-output round-robin scan starting at ptr; a grant needs a free (or draining) slot.
  always_comb begin
    scan_idx = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      can_load[o]  = !out_valid_q[o] || out_ready[o];
      win_found[o] = 1'b0;
      win_idx[o]   = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        scan_idx = ptr_q[o] + PW'(k);
        if (!win_found[o] && in_valid[scan_idx] && (dest[scan_idx] == PW'(o))) begin
          win_found[o] = 1'b1;
          win_idx[o]   = scan_idx;
        end
      end
      grant[o] = !reset && can_load[o] && win_found[o];
    end
  end

  // An input is ready when the output it targets granted it.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (grant[o] && (win_idx[o] == PW'(i))) begin
          in_ready[i] = 1'b1;
        end
      end
    end
  end

  // Slot next state: load on grant, empty on drain without refill, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (grant[o]) begin
        out_valid_d[o]                       = 1'b1;
        out_data_d[o*DATA_WIDTH +: DATA_WIDTH] = in_data[win_idx[o]*DATA_WIDTH +: DATA_WIDTH];
        out_src_d[o*PW +: PW]                = win_idx[o];
        ptr_d[o]                             = win_idx[o] + PW'(1);
      end else if (out_ready[o]) begin
        out_valid_d[o] = 1'b0;
      end
    end
  end

  // Slot and pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        ptr_q[o] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef ROUTER_ARB_STATS_EN
  logic [NUM_PORTS*16-1:0] grant_count_q, grant_count_d;

  // Saturating per-output grant counters.
  always_comb begin
    grant_count_d = grant_count_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (grant[o] && (grant_count_q[o*16 +: 16] != 16'hFFFF)) begin
        grant_count_d[o*16 +: 16] = grant_count_q[o*16 +: 16] + 16'd1;
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_count_q <= '0;
    end else begin
      grant_count_q <= grant_count_d;
    end
  end

  assign grant_count = grant_count_q;
`endif

endmodule

// File: tb/tb_router_rr_arbiter.sv
// tb/tb_router_rr_arbiter.sv - scoreboard bench for router_rr_arbiter
module tb_router_rr_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NP = 4;
  localparam int PW = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NP*AW-1:0]   in_addr;
  logic [NP*DW-1:0]   in_data;
  logic [NP-1:0]      in_valid;
  logic [NP-1:0]      in_ready;
  logic [NP*DW-1:0]   out_data;
  logic [NP-1:0]      out_valid;
  logic [NP-1:0]      out_ready;
  logic [NP*PW-1:0]   out_src;
`ifdef ROUTER_ARB_STATS_EN
  logic [NP*16-1:0]   grant_count;
`endif

  router_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
`ifdef ROUTER_ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Expected words per output: {src, data}.
  logic [PW+DW-1:0] exp_q [NP][$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int i, input logic [31:0] a, input logic [31:0] d);
    in_addr[i*AW +: AW] = a;
    in_data[i*DW +: DW] = d;
  endtask

  // One clock: check in_ready, pop drained outputs, push expected grants, then advance.
  task automatic step(input string tag, input logic [NP-1:0] exp_rdy);
    logic [PW+DW-1:0] e;
    logic [PW-1:0]    d;
    @(negedge clk);
    check({tag, " in_ready"}, 64'(in_ready), 64'(exp_rdy));
    if (!reset) begin
      for (int o = 0; o < NP; o++) begin
        if (out_valid[o] && out_ready[o]) begin
          if (exp_q[o].size() == 0) begin
            check($sformatf("%s unexpected out%0d", tag, o), 64'(out_valid[o]), 64'd0);
          end else begin
            e = exp_q[o].pop_front();
            check($sformatf("%s out%0d data", tag, o), 64'(out_data[o*DW +: DW]), 64'(e[DW-1:0]));
            check($sformatf("%s out%0d src", tag, o), 64'(out_src[o*PW +: PW]), 64'(e[PW+DW-1:DW]));
          end
        end
      end
      for (int i = 0; i < NP; i++) begin
        if (exp_rdy[i] && in_valid[i]) begin
          d = in_addr[i*AW +: PW];
          exp_q[d].push_back({PW'(i), in_data[i*DW +: DW]});
        end
      end
    end else begin
      for (int o = 0; o < NP; o++) exp_q[o].delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " out_data"}, 64'(|out_data), 64'd0);
    check({tag, " out_src"}, 64'(out_src), 64'd0);
`ifdef ROUTER_ARB_STATS_EN
    check({tag, " grant_count"}, 64'(|grant_count), 64'd0);
`endif
  endtask

  initial begin
    reset = 1'b1; in_valid = '0; out_ready = '1; in_addr = '0; in_data = '0;
    for (int i = 0; i < NP; i++) set_in(i, 32'(i), 32'hDEAD_0000 + 32'(i));

    // 1. Reset with all inputs requesting
    in_valid = 4'hF;
    for (int c = 0; c < 2; c++) begin
      step("rst", 4'b0000);
      check_reset_state("rst");
    end
    reset = 1'b0;
    in_valid = '0;
    step("idle", 4'b0000);

    // 2. Single path input 0 -> output 2
    set_in(0, 32'h0000_0002, 32'hA5A5_0001);
    in_valid = 4'b0001;
    step("single", 4'b0001);
    in_valid = '0;
    check("single out_valid", 64'(out_valid), 64'b0100);
    check("single data2", 64'(out_data[2*DW +: DW]), 64'hA5A5_0001);
    check("single src2", 64'(out_src[2*PW +: PW]), 64'd0);
    step("single drain", 4'b0000);

    // 3. Fairness: all inputs target output 1 (upper address bits set)
    for (int i = 0; i < NP; i++) set_in(i, 32'hFFFF_FFF1 - 32'(i*16), 32'h1111_0000 + 32'(i));
    in_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step($sformatf("fair%0d", k), 4'(1 << (k % 4)));
      check($sformatf("fair%0d src1", k), 64'(out_src[1*PW +: PW]), 64'(k % 4));
    end
    in_valid = '0;
    step("fair drain", 4'b0000);

    // 4. Backpressure on output 3
    set_in(0, 32'h3, 32'hB0B0_0000);
    in_valid = 4'b0001;
    out_ready = 4'b0111;
    step("bp load", 4'b0001);
    set_in(2, 32'h3, 32'hB0B0_0002);
    in_valid = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      step($sformatf("bp stall%0d", c), 4'b0000);
      check($sformatf("bp stall%0d data3", c), 64'(out_data[3*DW +: DW]), 64'hB0B0_0000);
    end
    out_ready = 4'hF;
    step("bp release", 4'b0100);
    in_valid = '0;
    check("bp src3", 64'(out_src[3*PW +: PW]), 64'd2);
    step("bp drain", 4'b0000);

    // 5. Parallel: input i -> output 3-i
    for (int i = 0; i < NP; i++) set_in(i, 32'(3 - i), 32'hC0C0_0000 + 32'(i));
    in_valid = 4'hF;
    step("par", 4'hF);
    in_valid = '0;
    check("par out_valid", 64'(out_valid), 64'hF);
    check("par out_src", 64'(out_src), 64'h1B);
    step("par drain", 4'b0000);

    // 6. Mid-op reset with output 0 stalled and ptr[0] advanced to 2
    set_in(1, 32'h0, 32'hD0D0_0001);
    in_valid = 4'b0010;
    out_ready = 4'b1110;
    step("mid load", 4'b0010);
    in_valid = '0;
    step("mid stall", 4'b0000);
    check("mid full", 64'(out_valid[0]), 64'd1);
    reset = 1'b1;
    step("mid rst", 4'b0000);
    check_reset_state("mid rst");
    reset = 1'b0;
    out_ready = 4'hF;
    set_in(2, 32'h0, 32'hD0D0_0002);
    in_valid = 4'b0110;
    step("mid arb0", 4'b0010);
    step("mid arb1", 4'b0100);
    in_valid = '0;
    step("mid drain", 4'b0000);
    step("final", 4'b0000);

    for (int o = 0; o < NP; o++) begin
      check($sformatf("leftover out%0d", o), 64'(exp_q[o].size()), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
